// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: horizontal/vertical counters, sync decode and a
// two-stage pipeline that aligns blanking, sync and pixel colour at the pins.
`timescale 1ns/1ps
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 408,
  parameter int unsigned H_FRONT  = 13,
  parameter int unsigned H_SYNC   = 61,
  parameter int unsigned H_BACK   = 30,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter logic        H_POL    = 1'b0,
  parameter logic        V_POL    = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [2:0] RGB_IN,
  output logic [9:0] PIXEL_X,
  output logic [9:0] PIXEL_Y,
  output logic       ACTIVE,
  output logic       LINE_START,
  output logic       FRAME_START,
  output logic       R,
  output logic       G,
  output logic       B,
  output logic       HSYNC,
  output logic       VSYNC
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       act_now;
  logic       hs_now;
  logic       vs_now;
  logic       act_d;
  logic       hs_d;
  logic       vs_d;
  logic [2:0] rgb_q;
  logic       hsync_q;
  logic       vsync_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (EN) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Vertical sync is decoded every clock, so its edges land on the line wrap.
  assign act_now = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs_now  = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
  assign vs_now  = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);

  // Stage 1 holds the decode of counter state t; stage 2 meets the colour
  // the pixel source returns one enabled cycle after seeing that coordinate.
  always_ff @(posedge CLK) begin
    if (RST) begin
      act_d   <= 1'b0;
      hs_d    <= 1'b0;
      vs_d    <= 1'b0;
      rgb_q   <= 3'b000;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
    end else if (EN) begin
      act_d   <= act_now;
      hs_d    <= hs_now;
      vs_d    <= vs_now;
      rgb_q   <= act_d ? RGB_IN : 3'b000;
      hsync_q <= hs_d ? H_POL : ~H_POL;
      vsync_q <= vs_d ? V_POL : ~V_POL;
    end
  end

  assign PIXEL_X     = h_cnt;
  assign PIXEL_Y     = v_cnt;
  assign ACTIVE      = act_now;
  assign LINE_START  = EN && (h_cnt == 10'd0);
  assign FRAME_START = EN && (h_cnt == 10'd0) && (v_cnt == 10'd0);
  assign R           = rgb_q[2];
  assign G           = rgb_q[1];
  assign B           = rgb_q[0];
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Scoreboard bench for vga_timing_ctrl: default line timing, a shortened
// 13-line frame so whole frames and the frame wrap fit in a short run.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;

  localparam int unsigned H_ACTIVE = 408;
  localparam int unsigned H_FRONT  = 13;
  localparam int unsigned H_SYNC   = 61;
  localparam int unsigned H_BACK   = 30;
  localparam int unsigned V_ACTIVE = 6;
  localparam int unsigned V_FRONT  = 2;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BACK   = 3;

  // Hand-derived timing: 512-clock line, 13-line frame, sync at 421..481 / 8..9.
  localparam int unsigned H_TOT    = 512;
  localparam int unsigned V_TOT    = 13;
  localparam int unsigned FRAME    = 6656;
  localparam int unsigned HS_FIRST = 421;
  localparam int unsigned HS_LAST  = 481;
  localparam int unsigned VS_FIRST = 8;
  localparam int unsigned VS_LAST  = 9;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       ls;
    logic       fs;
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] rgb_in;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       active;
  logic       line_start;
  logic       frame_start;
  logic       r;
  logic       g;
  logic       b;
  logic       hsync;
  logic       vsync;

  logic        src_mode;
  logic [2:0]  src_reg;
  exp_t        sb[$];
  int unsigned n_state;
  logic        model_valid;
  int          checks;
  int          failures;

  vga_timing_ctrl #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .H_POL(1'b0), .V_POL(1'b0)
  ) dut (
    .CLK(clk), .RST(rst), .EN(en), .RGB_IN(rgb_in),
    .PIXEL_X(pixel_x), .PIXEL_Y(pixel_y), .ACTIVE(active),
    .LINE_START(line_start), .FRAME_START(frame_start),
    .R(r), .G(g), .B(b), .HSYNC(hsync), .VSYNC(vsync)
  );

  always #5 clk = ~clk;

  // Pixel source: registered lookup, so colour arrives one enabled cycle late.
  always @(posedge clk) begin
    if (en) src_reg <= {pixel_x[0], ~pixel_x[0], pixel_y[0]};
  end
  assign rgb_in = src_mode ? src_reg : 3'b101;

  // Expected outputs while the counters sit at the n-th enabled state after reset.
  function automatic exp_t model(input int unsigned n, input logic en_now, input logic mode);
    exp_t e;
    int unsigned h, v, m, hm, vm;
    e = '0;
    h = n % H_TOT;
    v = (n / H_TOT) % V_TOT;
    e.x   = 10'(h);
    e.y   = 10'(v);
    e.act = (h < H_ACTIVE) && (v < V_ACTIVE);
    e.ls  = en_now && (h == 0);
    e.fs  = en_now && (h == 0) && (v == 0);
    e.rgb = 3'b000;
    e.hs  = 1'b1;
    e.vs  = 1'b1;
    if (n >= 2) begin
      m  = n - 2;
      hm = m % H_TOT;
      vm = (m / H_TOT) % V_TOT;
      if ((hm < H_ACTIVE) && (vm < V_ACTIVE))
        e.rgb = mode ? {1'(hm % 2), 1'((hm + 1) % 2), 1'(vm % 2)} : 3'b101;
      e.hs = !((hm >= HS_FIRST) && (hm <= HS_LAST));
      e.vs = !((vm >= VS_FIRST) && (vm <= VS_LAST));
    end
    return e;
  endfunction

  task automatic apply_stimulus(input logic en_v, input logic rst_v);
    en  = en_v;
    rst = rst_v;
    if (model_valid) sb.push_back(model(n_state, en_v, src_mode));
    @(posedge clk);
    #1;
    if (rst_v) begin
      n_state     = 0;
      model_valid = 1'b1;
    end else if (en_v) begin
      n_state = n_state + 1;
    end
  endtask

  task automatic check_output(input exp_t e);
    exp_t got;
    got     = '0;
    got.x   = pixel_x;
    got.y   = pixel_y;
    got.act = active;
    got.ls  = line_start;
    got.fs  = frame_start;
    got.rgb = {r, g, b};
    got.hs  = hsync;
    got.vs  = vsync;
    checks++;
    if ({got.x, got.y, got.act, got.ls, got.fs} !== {e.x, e.y, e.act, e.ls, e.fs}) begin
      failures++;
      $display("[TB] FAIL timing t=%0t got x=%0d y=%0d act=%b ls=%b fs=%b want x=%0d y=%0d act=%b ls=%b fs=%b",
               $time, got.x, got.y, got.act, got.ls, got.fs, e.x, e.y, e.act, e.ls, e.fs);
    end
    checks++;
    if ({got.rgb, got.hs, got.vs} !== {e.rgb, e.hs, e.vs}) begin
      failures++;
      $display("[TB] FAIL pins t=%0t x=%0d y=%0d got rgb=%b hs=%b vs=%b want rgb=%b hs=%b vs=%b",
               $time, got.x, got.y, got.rgb, got.hs, got.vs, e.rgb, e.hs, e.vs);
    end
  endtask

  // Monitor: outputs are presented every cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (sb.size() != 0) check_output(sb.pop_front());
  end

  initial begin
    clk         = 1'b0;
    rst         = 1'b1;
    en          = 1'b0;
    src_mode    = 1'b0;
    src_reg     = 3'b000;
    n_state     = 0;
    model_valid = 1'b0;
    checks      = 0;
    failures    = 0;

    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1);

    // Constant colour at full rate: one whole frame plus the wrap into the next.
    for (int i = 0; i < FRAME + 600; i++) apply_stimulus(1'b1, 1'b0);

    // Reset mid-frame at (200, 3), switching to the coordinate-driven source.
    while ((n_state % FRAME) != (3 * H_TOT + 200)) apply_stimulus(1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1);
    src_mode = 1'b1;
    apply_stimulus(1'b1, 1'b1);
    apply_stimulus(1'b1, 1'b1);

    // Half-rate enable: every period doubles, alignment must still hold.
    for (int i = 0; i < 2 * FRAME + 400; i++) apply_stimulus(i % 2 == 0, 1'b0);

    // Irregular enable pattern across a few lines.
    for (int i = 0; i < 3000; i++) apply_stimulus($urandom_range(0, 3) != 0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain got pending=%0d want pending=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
